branch_target_gen: RTL and testbench
====================================

BRANCH_TARGET_GEN -- requirements
Module: branch_target_gen

Interface
REQ-001 SHALL expose parameters, one per line: name, default, meaning.
  - IMM_W  24  immediate field width; legal range 8..31.
  - ADDR_W  32  address/data width.
  - SHIFT  2  left-shift amount applied after extension; legal range 0..3.
  - PC_OFFSET  8  constant added to pc in the branch modes.
REQ-002 SHALL expose ports, one per line: name, direction, width, meaning.
  - clk  in  1  single clock; all state updates on the rising edge.
  - reset  in  1  asynchronous, active-high reset.
  - in_valid  in  1  request present.
  - in_ready  out  1  request accepted when in_valid && in_ready.
  - imm  in  IMM_W  raw immediate field.
  - pc  in  ADDR_W  address of the requesting instruction.
  - mode  in  2  00 zero-extend, 01 sign-extend, 10 branch, 11 branch-with-link.
  - out_valid  out  1  result present.
  - out_ready  in  1  result consumed when out_valid && out_ready.
  - ext_imm  out  ADDR_W  extended and shifted immediate.
  - target  out  ADDR_W  branch target address.
  - link_addr  out  ADDR_W  return address.
  - is_link  out  1  result came from mode 11.
  - overflow  out  1  extended and shifted immediate did not fit in ADDR_W.
  - branch_count  out  16  number of branch results delivered.

Function
REQ-003 SHALL use a 2-stage valid/ready pipeline.
  - S1 registers the extended and shifted immediate, overflow, mode, pc.
  - S2 registers target, link_addr and is_link.
  - Latency from input handshake to out_valid is exactly 2 cycles when not stalled.
REQ-004 SHALL sustain 1 result per cycle when out_ready is held at 1.
REQ-005 SHALL compute the S1 extension.
  - Modes 00: zero-extend imm to ADDR_W+SHIFT bits.
  - Modes 01, 10, 11: sign-extend imm from bit IMM_W-1 to ADDR_W+SHIFT bits.
  - Then shift left by SHIFT and keep the low ADDR_W bits as ext_imm.
REQ-006 SHALL set overflow under these conditions.
  - Mode 00: any discarded upper bit is 1.
  - Other modes: the discarded bits and bit ADDR_W-1 of the shifted value are not all equal.
  - overflow SHALL be 0 whenever IMM_W+SHIFT < ADDR_W.
REQ-007 SHALL compute the S2 results.
  - target = pc + PC_OFFSET + ext_imm, modulo 2^ADDR_W, for modes 10/11.
  - target = ext_imm for modes 00/01.
  - link_addr = pc + 4, modulo 2^ADDR_W, in all modes.
  - is_link = (mode == 11).
REQ-008 SHALL propagate overflow with its result; overflow never blocks the pipeline.
REQ-009 SHALL follow these stall rules.
  - A stage advances when it is empty or the stage after it is advancing/consumed.
  - in_ready = !S1_valid || S1 advancing (purely combinational; in_valid does not feed it).
REQ-010 SHALL hold all outputs stable while out_valid && !out_ready.
  - Outputs SHALL NOT change until the handshake completes.
REQ-011 SHALL treat the same-cycle case as a move, not a stall: with S2 consumed and a new input accepted, both stages update on that edge.
REQ-012 SHALL increment branch_count by 1 on each output handshake with mode 10 or 11.
  - Saturates at 16'hFFFF.
  - Not affected by modes 00/01.
REQ-013 SHALL ignore imm, pc and mode while in_valid is 0; X on these inputs SHALL NOT reach any state.

Reset
REQ-014 SHALL, on reset assertion, asynchronously clear:
  - both stage valid bits;
  - out_valid, ext_imm, target, link_addr, is_link, overflow and branch_count, all to 0.
REQ-015 SHALL drive in_ready to 0 while reset is high and to 1 on the first cycle after deassertion.
REQ-016 SHALL discard any in-flight request on reset; no result for it is ever presented.

Verification
REQ-017 SHALL cover sign extension.
  - Stimulus: default parameters, mode 01, imm=24'hFFFFFF.
  - Response: ext_imm=32'hFFFFFFFC and overflow=0, 2 cycles after acceptance.
REQ-018 SHALL cover branch with link.
  - Stimulus: mode 11, pc=32'h00000100, imm=24'hFFFFFE.
  - Response: ext_imm=32'hFFFFFFF8, target=32'h00000100, link_addr=32'h00000104, is_link=1, branch_count becomes 1.
REQ-019 SHALL cover overflow.
  - Stimulus: IMM_W=31, mode 01, imm=31'h20000000.
  - Response: ext_imm=32'h80000000, overflow=1.
REQ-020 SHALL cover back-pressure.
  - Stimulus: continuous in_valid with out_ready=0 for 4 cycles.
  - Response: exactly 2 requests accepted, in_ready=0 afterwards, outputs stable.
  - Then with out_ready=1: results delivered in order, one per cycle.
REQ-021 SHALL cover reset mid-operation.
  - Stimulus: assert reset 1 cycle after acceptance.
  - Response: out_valid=0 and branch_count=0 immediately; no stale result after deassertion.
REQ-022 SHALL cover counter saturation.
  - Stimulus: 65537 branch handshakes.
  - Response: branch_count=16'hFFFF.

Source files
------------

// File: rtl/branch_target_gen.sv
// branch_target_gen: two-stage valid/ready pipeline that extends and shifts
// an instruction immediate, then forms a branch target and return address.
//
// Ports
//   clk, reset          clock; asynchronous active-high reset
//   in_valid/in_ready   request handshake (imm, pc, mode)
//   mode                00 zero-ext, 01 sign-ext, 10 branch, 11 branch-with-link
//   out_valid/out_ready result handshake
//   ext_imm             extended, shifted immediate (low ADDR_W bits)
//   target              pc+PC_OFFSET+ext_imm for branch modes, else ext_imm
//   link_addr           pc + 4
//   is_link             result came from mode 11
//   overflow            shifted immediate did not fit in ADDR_W
//   branch_count        saturating count of delivered branch results
module branch_target_gen #(
  parameter int IMM_W     = 24,
  parameter int ADDR_W    = 32,
  parameter int SHIFT     = 2,
  parameter int PC_OFFSET = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IMM_W-1:0]  imm,
  input  logic [ADDR_W-1:0] pc,
  input  logic [1:0]        mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] ext_imm,
  output logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] link_addr,
  output logic              is_link,
  output logic              overflow,
  output logic [15:0]       branch_count
);

  // One extra bit beyond ADDR_W+SHIFT keeps the discarded slice non-empty
  // even when SHIFT is 0; it is always a copy of the extension bit.
  localparam int XW = ADDR_W + SHIFT + 1;
  localparam int DW = XW - ADDR_W;

  // ---------------- S1 combinational extension ----------------
  logic          w_sext;
  logic [XW-1:0] w_ext;
  logic [XW-1:0] w_shl;
  logic [DW-1:0] w_disc;
  logic [DW:0]   w_top;
  logic          w_ovf;

  assign w_sext = (mode != 2'b00);
  assign w_ext  = {{(XW-IMM_W){w_sext & imm[IMM_W-1]}}, imm};
  assign w_shl  = w_ext << SHIFT;
  assign w_disc = w_shl[XW-1:ADDR_W];
  // Signed result fits only if every discarded bit matches the new MSB.
  assign w_top  = {w_disc, w_shl[ADDR_W-1]};
  assign w_ovf  = w_sext ? !((&w_top) || !(|w_top)) : (|w_disc);

  // ---------------- handshake control ----------------
  logic r_s1_valid, r_s2_valid;
  logic w_s2_adv, w_s1_adv, w_s1_open, w_accept;

  assign w_s2_adv  = !r_s2_valid || out_ready;
  assign w_s1_adv  = r_s1_valid && w_s2_adv;
  assign w_s1_open = !r_s1_valid || w_s2_adv;
  assign w_accept  = in_valid && w_s1_open;
  assign in_ready  = !reset && w_s1_open;

  // ---------------- S1 registers ----------------
  logic [ADDR_W-1:0] r_s1_ext, r_s1_pc;
  logic              r_s1_ovf;
  logic [1:0]        r_s1_mode;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_ext   <= '0;
      r_s1_pc    <= '0;
      r_s1_ovf   <= 1'b0;
      r_s1_mode  <= 2'b00;
    end else begin
      if (w_s1_open) r_s1_valid <= in_valid;
      // Data only loads on an accepted request so idle-bus X never enters.
      if (w_accept) begin
        r_s1_ext  <= w_shl[ADDR_W-1:0];
        r_s1_pc   <= pc;
        r_s1_ovf  <= w_ovf;
        r_s1_mode <= mode;
      end
    end
  end

  // ---------------- S2 combinational results ----------------
  logic [ADDR_W-1:0] w_tgt, w_link;

  assign w_tgt  = r_s1_mode[1] ? (r_s1_pc + ADDR_W'(PC_OFFSET) + r_s1_ext) : r_s1_ext;
  assign w_link = r_s1_pc + ADDR_W'(4);

  // ---------------- S2 registers ----------------
  logic [ADDR_W-1:0] r_ext, r_tgt, r_link;
  logic              r_link_f, r_ovf, r_br;
  logic [15:0]       r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s2_valid <= 1'b0;
      r_ext      <= '0;
      r_tgt      <= '0;
      r_link     <= '0;
      r_link_f   <= 1'b0;
      r_ovf      <= 1'b0;
      r_br       <= 1'b0;
    end else begin
      if (w_s2_adv) r_s2_valid <= r_s1_valid;
      if (w_s1_adv) begin
        r_ext    <= r_s1_ext;
        r_tgt    <= w_tgt;
        r_link   <= w_link;
        r_link_f <= (r_s1_mode == 2'b11);
        r_ovf    <= r_s1_ovf;
        r_br     <= r_s1_mode[1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_cnt <= 16'h0000;
    else if (r_s2_valid && out_ready && r_br && (r_cnt != 16'hFFFF))
      r_cnt <= r_cnt + 16'd1;
  end

  assign out_valid    = r_s2_valid;
  assign ext_imm      = r_ext;
  assign target       = r_tgt;
  assign link_addr    = r_link;
  assign is_link      = r_link_f;
  assign overflow     = r_ovf;
  assign branch_count = r_cnt;

endmodule

// File: tb/tb_branch_target_gen.sv
module tb_branch_target_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0, out_ready = 1'b1;
  logic        in_ready, out_valid, is_link, overflow;
  logic [23:0] imm = '0;
  logic [31:0] pc = '0;
  logic [1:0]  mode = 2'b00;
  logic [31:0] ext_imm, target, link_addr;
  logic [15:0] branch_count;

  // Second instance for the wide-immediate overflow cases.
  logic        d2_in_valid = 1'b0, d2_out_ready = 1'b1;
  logic        d2_in_ready, d2_out_valid, d2_is_link, d2_overflow;
  logic [30:0] d2_imm = '0;
  logic [31:0] d2_pc = '0;
  logic [1:0]  d2_mode = 2'b00;
  logic [31:0] d2_ext_imm, d2_target, d2_link_addr;
  logic [15:0] d2_branch_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  branch_target_gen dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .imm(imm), .pc(pc), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .ext_imm(ext_imm), .target(target), .link_addr(link_addr), .is_link(is_link),
    .overflow(overflow), .branch_count(branch_count)
  );

  branch_target_gen #(.IMM_W(31)) dut2 (
    .clk(clk), .reset(reset), .in_valid(d2_in_valid), .in_ready(d2_in_ready),
    .imm(d2_imm), .pc(d2_pc), .mode(d2_mode), .out_valid(d2_out_valid),
    .out_ready(d2_out_ready), .ext_imm(d2_ext_imm), .target(d2_target),
    .link_addr(d2_link_addr), .is_link(d2_is_link), .overflow(d2_overflow),
    .branch_count(d2_branch_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request, let it be accepted, then idle the bus with X.
  task automatic send(input logic [1:0] m, input logic [23:0] i, input logic [31:0] p);
    in_valid = 1'b1; mode = m; imm = i; pc = p;
    tick();
    in_valid = 1'b0; mode = 'x; imm = 'x; pc = 'x;
    tick();
  endtask

  task automatic send2(input logic [1:0] m, input logic [30:0] i);
    d2_in_valid = 1'b1; d2_mode = m; d2_imm = i; d2_pc = 32'h0;
    tick();
    d2_in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    tick(); tick();
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready got %b exp 0", in_ready); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    n_vec++; if (branch_count !== 16'h0) begin n_err++; $display("FAIL rst_count got %h exp 0", branch_count); end
    n_vec++; if ({ext_imm, target, link_addr} !== 96'h0) begin n_err++; $display("FAIL rst_data got %h %h %h exp 0", ext_imm, target, link_addr); end
    reset = 1'b0;
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_ready got %b exp 1", in_ready); end
    // Idle bus carrying X must not disturb anything.
    imm = 'x; pc = 'x; mode = 'x;
    tick(); tick();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL idle_x_out_valid got %b exp 0", out_valid); end
  endtask

  task automatic test_sign_ext();
    in_valid = 1'b1; mode = 2'b01; imm = 24'hFFFFFF; pc = 32'h200;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL sext_ready got %b exp 1", in_ready); end
    tick();
    in_valid = 1'b0; mode = 'x; imm = 'x; pc = 'x;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL sext_lat1 got %b exp 0", out_valid); end
    tick();
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL sext_lat2 got %b exp 1", out_valid); end
    n_vec++; if (ext_imm !== 32'hFFFFFFFC) begin n_err++; $display("FAIL sext_ext got %h exp fffffffc", ext_imm); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL sext_ovf got %b exp 0", overflow); end
    n_vec++; if (target !== 32'hFFFFFFFC) begin n_err++; $display("FAIL sext_target got %h exp fffffffc", target); end
    n_vec++; if (link_addr !== 32'h204) begin n_err++; $display("FAIL sext_link got %h exp 204", link_addr); end
    tick();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL sext_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_zero_ext();
    send(2'b00, 24'hC00001, 32'h300);
    n_vec++; if (ext_imm !== 32'h03000004) begin n_err++; $display("FAIL zext_ext got %h exp 03000004", ext_imm); end
    n_vec++; if (target !== 32'h03000004) begin n_err++; $display("FAIL zext_target got %h exp 03000004", target); end
    n_vec++; if ({is_link, overflow} !== 2'b00) begin n_err++; $display("FAIL zext_flags got %b exp 00", {is_link, overflow}); end
    tick();
    n_vec++; if (branch_count !== 16'h0) begin n_err++; $display("FAIL zext_count got %h exp 0", branch_count); end
  endtask

  task automatic test_branch_link();
    send(2'b11, 24'hFFFFFE, 32'h100);
    n_vec++; if (ext_imm !== 32'hFFFFFFF8) begin n_err++; $display("FAIL bl_ext got %h exp fffffff8", ext_imm); end
    n_vec++; if (target !== 32'h100) begin n_err++; $display("FAIL bl_target got %h exp 100", target); end
    n_vec++; if (link_addr !== 32'h104) begin n_err++; $display("FAIL bl_link got %h exp 104", link_addr); end
    n_vec++; if (is_link !== 1'b1) begin n_err++; $display("FAIL bl_is_link got %b exp 1", is_link); end
    n_vec++; if (branch_count !== 16'h0) begin n_err++; $display("FAIL bl_count_pre got %h exp 0", branch_count); end
    tick();
    n_vec++; if (branch_count !== 16'h1) begin n_err++; $display("FAIL bl_count got %h exp 1", branch_count); end
  endtask

  task automatic test_branch();
    send(2'b10, 24'h000010, 32'h1000);
    n_vec++; if (target !== 32'h1048) begin n_err++; $display("FAIL br_target got %h exp 1048", target); end
    n_vec++; if (link_addr !== 32'h1004) begin n_err++; $display("FAIL br_link got %h exp 1004", link_addr); end
    n_vec++; if (is_link !== 1'b0) begin n_err++; $display("FAIL br_is_link got %b exp 0", is_link); end
    tick();
    // Most negative immediate wraps the target address.
    send(2'b10, 24'h800000, 32'h0);
    n_vec++; if (ext_imm !== 32'hFE000000) begin n_err++; $display("FAIL brneg_ext got %h exp fe000000", ext_imm); end
    n_vec++; if (target !== 32'hFE000008) begin n_err++; $display("FAIL brneg_target got %h exp fe000008", target); end
    tick();
    n_vec++; if (branch_count !== 16'h3) begin n_err++; $display("FAIL br_count got %h exp 3", branch_count); end
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1; mode = 2'b01; imm = 24'd1; pc = 32'h0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k >= 2 && k <= 4) begin
        n_vec++; if (out_valid !== 1'b1 || ext_imm !== 32'(4 * (k - 1))) begin
          n_err++; $display("FAIL b2b_%0d got v=%b ext=%h exp v=1 ext=%h", k, out_valid, ext_imm, 32'(4 * (k - 1)));
        end
      end else begin
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_%0d_valid got %b exp 0", k, out_valid); end
      end
      if (k < 3) begin
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_%0d got %b exp 1", k, in_ready); end
        imm = 24'(k + 1);
      end else begin
        in_valid = 1'b0; imm = 'x;
      end
    end
  endtask

  task automatic test_backpressure();
    int acc = 0;
    logic w;
    logic [3:0] exp_rdy = 4'b0011;   // bit c = in_ready expected in cycle c
    out_ready = 1'b0;
    in_valid = 1'b1; mode = 2'b01; imm = 24'd5; pc = 32'h0;
    for (int c = 0; c < 4; c++) begin
      w = in_ready;
      n_vec++; if (w !== exp_rdy[c]) begin n_err++; $display("FAIL bp_ready_%0d got %b exp %b", c, w, exp_rdy[c]); end
      tick();
      if (w === 1'b1) begin acc++; imm = 24'(5 + acc); end
      if (c >= 2) begin
        n_vec++; if (out_valid !== 1'b1 || ext_imm !== 32'h14) begin
          n_err++; $display("FAIL bp_hold_%0d got v=%b ext=%h exp v=1 ext=14", c, out_valid, ext_imm);
        end
      end
    end
    n_vec++; if (acc != 2) begin n_err++; $display("FAIL bp_accepted got %0d exp 2", acc); end
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_after got %b exp 0", in_ready); end
    in_valid = 1'b0; imm = 'x;
    out_ready = 1'b1;
    tick();
    n_vec++; if (out_valid !== 1'b1 || ext_imm !== 32'h18) begin
      n_err++; $display("FAIL bp_second got v=%b ext=%h exp v=1 ext=18", out_valid, ext_imm);
    end
    tick();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_overflow();
    send2(2'b01, 31'h20000000);
    n_vec++; if (d2_out_valid !== 1'b1 || d2_ext_imm !== 32'h80000000 || d2_overflow !== 1'b1) begin
      n_err++; $display("FAIL ovf_pos got v=%b ext=%h ovf=%b exp v=1 ext=80000000 ovf=1", d2_out_valid, d2_ext_imm, d2_overflow);
    end
    tick();
    send2(2'b00, 31'h40000000);
    n_vec++; if (d2_ext_imm !== 32'h0 || d2_overflow !== 1'b1) begin
      n_err++; $display("FAIL ovf_zext got ext=%h ovf=%b exp ext=0 ovf=1", d2_ext_imm, d2_overflow);
    end
    tick();
    send2(2'b01, 31'h10000000);
    n_vec++; if (d2_ext_imm !== 32'h40000000 || d2_overflow !== 1'b0) begin
      n_err++; $display("FAIL ovf_fit got ext=%h ovf=%b exp ext=40000000 ovf=0", d2_ext_imm, d2_overflow);
    end
    tick();
    send2(2'b01, 31'h60000000);
    n_vec++; if (d2_ext_imm !== 32'h80000000 || d2_overflow !== 1'b0) begin
      n_err++; $display("FAIL ovf_negfit got ext=%h ovf=%b exp ext=80000000 ovf=0", d2_ext_imm, d2_overflow);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    send(2'b10, 24'h000004, 32'h0);
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rmid_pre_valid got %b exp 1", out_valid); end
    reset = 1'b1;
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rmid_valid got %b exp 0", out_valid); end
    n_vec++; if (branch_count !== 16'h0) begin n_err++; $display("FAIL rmid_count got %h exp 0", branch_count); end
    n_vec++; if (in_ready !== 1'b0 || target !== 32'h0) begin n_err++; $display("FAIL rmid_state got rdy=%b tgt=%h exp 0 0", in_ready, target); end
    tick(); tick();
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_vec++; if (out_valid !== 1'b0 || branch_count !== 16'h0) begin
        n_err++; $display("FAIL rmid_stale_%0d got v=%b cnt=%h exp 0 0", c, out_valid, branch_count);
      end
    end
  endtask

  task automatic test_saturation();
    int stalls = 0;
    in_valid = 1'b1; mode = 2'b10; imm = 24'h0; pc = 32'h0; out_ready = 1'b1;
    for (int n = 0; n < 65534; n++) begin
      if (in_ready !== 1'b1) stalls++;
      tick();
    end
    in_valid = 1'b0;
    tick(); tick(); tick();
    n_vec++; if (stalls != 0) begin n_err++; $display("FAIL sat_stalls got %0d exp 0", stalls); end
    n_vec++; if (branch_count !== 16'hFFFE) begin n_err++; $display("FAIL sat_fffe got %h exp fffe", branch_count); end
    in_valid = 1'b1;
    tick(); tick(); tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    n_vec++; if (branch_count !== 16'hFFFF) begin n_err++; $display("FAIL sat_ffff got %h exp ffff", branch_count); end
  endtask

  initial begin
    test_reset();
    test_sign_ext();
    test_zero_ext();
    test_branch_link();
    test_branch();
    test_back_to_back();
    test_backpressure();
    test_overflow();
    test_reset_mid();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
